// File: rtl/tmb_fiber_tx_seq_if.sv
// Control/status bundle between the TMB fiber TX sequencer and its environment.
// The sequencer itself connects through the slave modport; the controller/GTX
// side (or a testbench) uses the master modport.
interface tmb_fiber_tx_seq_if;
  logic       ENA;
  logic       FORCE_RESYNC;
  logic       TRG_TX_PLL_LOCK;
  logic       TRG_TXRESETDONE;
  logic       TX_SYNC_DONE;
  logic       TRG_TX_PLLRST;
  logic       TRG_GTXTXRST;
  logic       TRG_RST;
  logic       LINK_UP;
  logic [2:0] STATE;
  logic [7:0] RETRY_CNT;
  logic [7:0] LOSS_CNT;

  modport slave (
    input  ENA, FORCE_RESYNC, TRG_TX_PLL_LOCK, TRG_TXRESETDONE, TX_SYNC_DONE,
    output TRG_TX_PLLRST, TRG_GTXTXRST, TRG_RST, LINK_UP, STATE, RETRY_CNT, LOSS_CNT
  );

  modport master (
    output ENA, FORCE_RESYNC, TRG_TX_PLL_LOCK, TRG_TXRESETDONE, TX_SYNC_DONE,
    input  TRG_TX_PLLRST, TRG_GTXTXRST, TRG_RST, LINK_UP, STATE, RETRY_CNT, LOSS_CNT
  );
endinterface

// File: rtl/tmb_fiber_tx_seq.sv
// Power-up / recovery sequencer for the TMB trigger fiber transmitter.
// Walks PLL reset -> lock wait -> GTX TX reset -> reset-done wait -> phase-align
// wait -> comma-only interval -> RUN, and restarts on timeout or loss of
// lock/reset-done. Outputs are registered from the next-state value so they
// change on the same edge as STATE.
module tmb_fiber_tx_seq #(
  parameter int unsigned PLLRST_CYC  = 16,
  parameter int unsigned GTXRST_CYC  = 16,
  parameter int unsigned WAIT_TMO    = 50000,
  parameter int unsigned COMMA_CYC   = 256,
  parameter int unsigned SIM_SPEEDUP = 0
) (
  input logic               TRG_CLK80,
  input logic               RST,
  tmb_fiber_tx_seq_if.slave fib
);

  localparam int unsigned WAIT_N  = (SIM_SPEEDUP != 0) ? 32'd64 : WAIT_TMO;
  localparam int unsigned COMMA_N = (SIM_SPEEDUP != 0) ? 32'd64 : COMMA_CYC;

  localparam logic [15:0] LD_PLLRST = 16'(PLLRST_CYC - 1);
  localparam logic [15:0] LD_GTXRST = 16'(GTXRST_CYC - 1);
  localparam logic [15:0] LD_WAIT   = 16'(WAIT_N - 1);
  localparam logic [15:0] LD_COMMA  = 16'(COMMA_N - 1);

  typedef enum logic [2:0] {
    OFF       = 3'd0,
    PLL_RST   = 3'd1,
    PLL_WAIT  = 3'd2,
    GTX_RST   = 3'd3,
    DONE_WAIT = 3'd4,
    SYNC_WAIT = 3'd5,
    COMMA     = 3'd6,
    RUN       = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_ld;
  logic        reload;
  logic        retry_inc, loss_inc;
  logic [7:0]  retry_q, loss_q;
  logic        pllrst_q, gtxrst_q, trgrst_q, linkup_q;

  logic [1:0]  lock_sync, rdone_sync, sdone_sync;
  logic [2:0]  resync_sync;
  logic        lock_s, rdone_s, sdone_s, resync_edge;
  logic        lock_loss, rdone_loss;

  assign lock_s      = lock_sync[1];
  assign rdone_s     = rdone_sync[1];
  assign sdone_s     = sdone_sync[1];
  assign resync_edge = resync_sync[1] & ~resync_sync[2];

  assign lock_loss  = !lock_s  && (state_q inside {GTX_RST, DONE_WAIT, SYNC_WAIT, COMMA, RUN});
  assign rdone_loss = !rdone_s && (state_q inside {SYNC_WAIT, COMMA, RUN});

  // Two-flop synchronizers for the asynchronous GTX status and the resync request.
  always_ff @(posedge TRG_CLK80 or posedge RST) begin
    if (RST) begin
      lock_sync   <= '0;
      rdone_sync  <= '0;
      sdone_sync  <= '0;
      resync_sync <= '0;
    end else begin
      lock_sync   <= {lock_sync[0],  fib.TRG_TX_PLL_LOCK};
      rdone_sync  <= {rdone_sync[0], fib.TRG_TXRESETDONE};
      sdone_sync  <= {sdone_sync[0], fib.TX_SYNC_DONE};
      resync_sync <= {resync_sync[1:0], fib.FORCE_RESYNC};
    end
  end

  // Next-state selection, in priority order: disable, resync, lock loss,
  // reset-done loss, then the per-state advance/timeout.
  always_comb begin
    state_d   = state_q;
    reload    = 1'b0;
    retry_inc = 1'b0;
    loss_inc  = 1'b0;
    if (!fib.ENA) begin
      state_d = OFF;
      reload  = (state_q != OFF);
    end else if (resync_edge) begin
      // Re-entry into PLL_RST from PLL_RST must still restart the pulse timer.
      state_d = PLL_RST;
      reload  = 1'b1;
    end else if (lock_loss) begin
      state_d  = PLL_RST;
      reload   = 1'b1;
      loss_inc = (state_q == RUN);
    end else if (rdone_loss) begin
      state_d  = GTX_RST;
      reload   = 1'b1;
      loss_inc = (state_q == RUN);
    end else begin
      case (state_q)
        OFF: begin
          state_d = PLL_RST;
          reload  = 1'b1;
        end
        PLL_RST: if (timer_q == '0) begin
          state_d = PLL_WAIT;
          reload  = 1'b1;
        end
        PLL_WAIT: if (lock_s) begin
          state_d = GTX_RST;
          reload  = 1'b1;
        end else if (timer_q == '0) begin
          state_d   = PLL_RST;
          reload    = 1'b1;
          retry_inc = 1'b1;
        end
        GTX_RST: if (timer_q == '0) begin
          state_d = DONE_WAIT;
          reload  = 1'b1;
        end
        DONE_WAIT: if (rdone_s) begin
          state_d = SYNC_WAIT;
          reload  = 1'b1;
        end else if (timer_q == '0) begin
          state_d   = PLL_RST;
          reload    = 1'b1;
          retry_inc = 1'b1;
        end
        SYNC_WAIT: if (sdone_s) begin
          state_d = COMMA;
          reload  = 1'b1;
        end else if (timer_q == '0) begin
          state_d   = GTX_RST;
          reload    = 1'b1;
          retry_inc = 1'b1;
        end
        COMMA: if (timer_q == '0) begin
          state_d = RUN;
          reload  = 1'b1;
        end
        RUN: ;
      endcase
    end
  end

  // Timer reload value for the state being entered.
  always_comb begin
    timer_ld = '0;
    case (state_d)
      PLL_RST:                       timer_ld = LD_PLLRST;
      GTX_RST:                       timer_ld = LD_GTXRST;
      PLL_WAIT, DONE_WAIT, SYNC_WAIT: timer_ld = LD_WAIT;
      COMMA:                         timer_ld = LD_COMMA;
      default:                       timer_ld = '0;
    endcase
  end

  // State register and down-counter that holds at zero.
  always_ff @(posedge TRG_CLK80 or posedge RST) begin
    if (RST) begin
      state_q <= OFF;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      if (reload)
        timer_q <= timer_ld;
      else if (timer_q != '0)
        timer_q <= timer_q - 16'd1;
    end
  end

  // Saturating retry and loss counters.
  always_ff @(posedge TRG_CLK80 or posedge RST) begin
    if (RST) begin
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      if (retry_inc && retry_q != '1) retry_q <= retry_q + 8'd1;
      if (loss_inc  && loss_q  != '1) loss_q  <= loss_q  + 8'd1;
    end
  end

  // Reset/link outputs decoded from the next state.
  always_ff @(posedge TRG_CLK80 or posedge RST) begin
    if (RST) begin
      pllrst_q <= 1'b1;
      gtxrst_q <= 1'b1;
      trgrst_q <= 1'b1;
      linkup_q <= 1'b0;
    end else begin
      pllrst_q <= (state_d inside {OFF, PLL_RST});
      gtxrst_q <= (state_d inside {OFF, PLL_RST, PLL_WAIT, GTX_RST});
      trgrst_q <= (state_d != RUN);
      linkup_q <= (state_d == RUN);
    end
  end

  assign fib.TRG_TX_PLLRST = pllrst_q;
  assign fib.TRG_GTXTXRST  = gtxrst_q;
  assign fib.TRG_RST       = trgrst_q;
  assign fib.LINK_UP       = linkup_q;
  assign fib.STATE         = state_q;
  assign fib.RETRY_CNT     = retry_q;
  assign fib.LOSS_CNT      = loss_q;

endmodule

// File: tb/tb_tmb_fiber_tx_seq.sv
// Directed bench for tmb_fiber_tx_seq: a nominal-timing instance driven by a
// small GTX response model, plus a SIM_SPEEDUP instance with no PLL lock.
module tb_tmb_fiber_tx_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tmb_fiber_tx_seq_if fib ();
  tmb_fiber_tx_seq_if fib_s ();

  tmb_fiber_tx_seq #(
    .PLLRST_CYC(16), .GTXRST_CYC(16), .WAIT_TMO(200), .COMMA_CYC(256), .SIM_SPEEDUP(0)
  ) dut (
    .TRG_CLK80(clk), .RST(rst), .fib(fib)
  );

  tmb_fiber_tx_seq #(
    .SIM_SPEEDUP(1)
  ) dut_s (
    .TRG_CLK80(clk), .RST(rst), .fib(fib_s)
  );

  // GTX model: each status rises 5 cycles after its request, drops while in reset.
  logic [2:0] lock_cnt = '0;
  logic [2:0] rd_cnt   = '0;
  logic [2:0] sy_cnt   = '0;
  logic       lock_kill = 1'b0;
  logic       rd_kill   = 1'b0;

  always @(posedge clk) begin
    if (fib.TRG_TX_PLLRST) lock_cnt <= '0;
    else if (lock_cnt != 3'd5) lock_cnt <= lock_cnt + 3'd1;
    if (fib.TRG_GTXTXRST) rd_cnt <= '0;
    else if (rd_cnt != 3'd5) rd_cnt <= rd_cnt + 3'd1;
    if (fib.TRG_GTXTXRST) sy_cnt <= '0;
    else if (rd_cnt == 3'd5 && sy_cnt != 3'd5) sy_cnt <= sy_cnt + 3'd1;
  end

  assign fib.TRG_TX_PLL_LOCK = (lock_cnt == 3'd5) && !lock_kill;
  assign fib.TRG_TXRESETDONE = (rd_cnt == 3'd5) && !rd_kill;
  assign fib.TX_SYNC_DONE    = (sy_cnt == 3'd5);

  assign fib_s.TRG_TX_PLL_LOCK = 1'b0;
  assign fib_s.TRG_TXRESETDONE = 1'b0;
  assign fib_s.TX_SYNC_DONE    = 1'b0;

  task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fib.STATE == s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic count_in_state(input logic [2:0] s, input int budget, output int n);
    n = 0;
    while (fib.STATE == s && n < budget) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    fib.ENA = 1'b0; fib.FORCE_RESYNC = 1'b0;
    fib_s.ENA = 1'b0; fib_s.FORCE_RESYNC = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (fib.STATE !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", fib.STATE); end
    n_chk++; if ({fib.TRG_TX_PLLRST, fib.TRG_GTXTXRST, fib.TRG_RST} !== 3'b111) begin n_fail++; $display("FAIL rst_resets: got %b want 111", {fib.TRG_TX_PLLRST, fib.TRG_GTXTXRST, fib.TRG_RST}); end
    n_chk++; if (fib.LINK_UP !== 1'b0) begin n_fail++; $display("FAIL rst_linkup: got %b want 0", fib.LINK_UP); end
    n_chk++; if ({fib.RETRY_CNT, fib.LOSS_CNT} !== 16'h0000) begin n_fail++; $display("FAIL rst_cnts: got %h want 0000", {fib.RETRY_CNT, fib.LOSS_CNT}); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_chk++; if (fib.STATE !== 3'd0) begin n_fail++; $display("FAIL off_hold: got %0d want 0", fib.STATE); end
  endtask

  task automatic test_nominal;
    bit ok;
    int n;
    int c0;
    fib.ENA = 1'b1;
    c0 = cyc;
    wait_state(3'd1, 10, ok);
    n_chk++; if (!ok || cyc - c0 != 1) begin n_fail++; $display("FAIL nom_enter_pllrst: got ok=%0d cyc=%0d want ok=1 cyc=1", ok, cyc - c0); end
    count_in_state(3'd1, 100, n);
    n_chk++; if (n != 16) begin n_fail++; $display("FAIL nom_pllrst_width: got %0d want 16", n); end
    n_chk++; if ({fib.STATE, fib.TRG_TX_PLLRST, fib.TRG_GTXTXRST} !== {3'd2, 1'b0, 1'b1}) begin n_fail++; $display("FAIL nom_pll_wait: got st=%0d p=%b g=%b want st=2 p=0 g=1", fib.STATE, fib.TRG_TX_PLLRST, fib.TRG_GTXTXRST); end
    wait_state(3'd3, 300, ok);
    n_chk++; if (!ok || fib.TRG_GTXTXRST !== 1'b1) begin n_fail++; $display("FAIL nom_gtx_rst: got ok=%0d g=%b want ok=1 g=1", ok, fib.TRG_GTXTXRST); end
    count_in_state(3'd3, 100, n);
    n_chk++; if (n != 16) begin n_fail++; $display("FAIL nom_gtxrst_width: got %0d want 16", n); end
    n_chk++; if ({fib.STATE, fib.TRG_GTXTXRST} !== {3'd4, 1'b0}) begin n_fail++; $display("FAIL nom_done_wait: got st=%0d g=%b want st=4 g=0", fib.STATE, fib.TRG_GTXTXRST); end
    wait_state(3'd6, 300, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL nom_reach_comma: got timeout want state 6"); end
    count_in_state(3'd6, 400, n);
    n_chk++; if (n != 256) begin n_fail++; $display("FAIL nom_comma_width: got %0d want 256", n); end
    n_chk++; if ({fib.STATE, fib.TRG_RST, fib.LINK_UP} !== {3'd7, 1'b0, 1'b1}) begin n_fail++; $display("FAIL nom_run: got st=%0d r=%b l=%b want st=7 r=0 l=1", fib.STATE, fib.TRG_RST, fib.LINK_UP); end
    n_chk++; if (fib.RETRY_CNT !== 8'd0) begin n_fail++; $display("FAIL nom_retry: got %0d want 0", fib.RETRY_CNT); end
    n_chk++; if (cyc - c0 != 310) begin n_fail++; $display("FAIL nom_bringup_time: got %0d want 310", cyc - c0); end
  endtask

  task automatic test_lock_loss;
    bit ok;
    lock_kill = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (fib.STATE !== 3'd7) begin n_fail++; $display("FAIL ll_latency: got %0d want 7", fib.STATE); end
    @(negedge clk);
    n_chk++; if ({fib.STATE, fib.LINK_UP, fib.TRG_RST} !== {3'd1, 1'b0, 1'b1}) begin n_fail++; $display("FAIL ll_react: got st=%0d l=%b r=%b want st=1 l=0 r=1", fib.STATE, fib.LINK_UP, fib.TRG_RST); end
    n_chk++; if (fib.LOSS_CNT !== 8'd1) begin n_fail++; $display("FAIL ll_loss_cnt: got %0d want 1", fib.LOSS_CNT); end
    repeat (7) @(negedge clk);
    lock_kill = 1'b0;
    wait_state(3'd7, 1000, ok);
    n_chk++; if (!ok || fib.LINK_UP !== 1'b1 || fib.LOSS_CNT !== 8'd1) begin n_fail++; $display("FAIL ll_replay: got ok=%0d l=%b loss=%0d want ok=1 l=1 loss=1", ok, fib.LINK_UP, fib.LOSS_CNT); end
  endtask

  task automatic test_force_resync;
    fib.FORCE_RESYNC = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (fib.STATE !== 3'd7) begin n_fail++; $display("FAIL rs_latency: got %0d want 7", fib.STATE); end
    @(negedge clk);
    n_chk++; if ({fib.STATE, fib.LINK_UP} !== {3'd1, 1'b0}) begin n_fail++; $display("FAIL rs_react: got st=%0d l=%b want st=1 l=0", fib.STATE, fib.LINK_UP); end
    n_chk++; if (fib.LOSS_CNT !== 8'd1) begin n_fail++; $display("FAIL rs_loss_cnt: got %0d want 1", fib.LOSS_CNT); end
    repeat (5) @(negedge clk);
    fib.FORCE_RESYNC = 1'b0;
  endtask

  task automatic test_rdone_loss_comma;
    bit ok;
    wait_state(3'd6, 400, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL rd_reach_comma: got timeout want state 6"); end
    repeat (10) @(negedge clk);
    rd_kill = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if ({fib.STATE, fib.TRG_GTXTXRST, fib.TRG_RST} !== {3'd3, 1'b1, 1'b1}) begin n_fail++; $display("FAIL rd_react: got st=%0d g=%b r=%b want st=3 g=1 r=1", fib.STATE, fib.TRG_GTXTXRST, fib.TRG_RST); end
    n_chk++; if (fib.LOSS_CNT !== 8'd1) begin n_fail++; $display("FAIL rd_loss_cnt: got %0d want 1", fib.LOSS_CNT); end
    rd_kill = 1'b0;
    wait_state(3'd7, 600, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL rd_recover: got timeout want state 7"); end
  endtask

  task automatic test_coincident;
    bit ok;
    lock_kill = 1'b1;
    fib.FORCE_RESYNC = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (fib.STATE !== 3'd1) begin n_fail++; $display("FAIL co_resync_lock: got %0d want 1", fib.STATE); end
    n_chk++; if (fib.LOSS_CNT !== 8'd1) begin n_fail++; $display("FAIL co_resync_loss: got %0d want 1", fib.LOSS_CNT); end
    repeat (7) @(negedge clk);
    lock_kill = 1'b0;
    fib.FORCE_RESYNC = 1'b0;
    wait_state(3'd7, 1000, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL co_recover: got timeout want state 7"); end
    fib.FORCE_RESYNC = 1'b1;
    repeat (2) @(negedge clk);
    fib.ENA = 1'b0;
    @(negedge clk);
    n_chk++; if ({fib.STATE, fib.TRG_TX_PLLRST, fib.TRG_GTXTXRST, fib.TRG_RST, fib.LINK_UP} !== {3'd0, 4'b1110}) begin n_fail++; $display("FAIL co_ena_resync: got st=%0d p=%b g=%b r=%b l=%b want st=0 p=1 g=1 r=1 l=0", fib.STATE, fib.TRG_TX_PLLRST, fib.TRG_GTXTXRST, fib.TRG_RST, fib.LINK_UP); end
  endtask

  task automatic test_pll_timeout;
    int k;
    int last;
    logic [2:0] prev;
    logic [7:0] want;
    k = 0; last = 0;
    prev = fib_s.STATE;
    fib_s.ENA = 1'b1;
    for (int n = 0; n < 30000 && k < 300; n++) begin
      @(negedge clk);
      if (fib_s.STATE == 3'd1 && prev == 3'd0) last = cyc;
      if (fib_s.STATE == 3'd1 && prev == 3'd2) begin
        k++;
        want = (k > 255) ? 8'd255 : 8'(k);
        if (k <= 3) begin
          n_chk++; if (cyc - last != 80) begin n_fail++; $display("FAIL to_period%0d: got %0d want 80", k, cyc - last); end
        end
        if (k <= 3 || k == 255 || k == 256 || k == 300) begin
          n_chk++; if (fib_s.RETRY_CNT !== want) begin n_fail++; $display("FAIL to_retry%0d: got %0d want %0d", k, fib_s.RETRY_CNT, want); end
        end
        last = cyc;
      end
      prev = fib_s.STATE;
    end
    n_chk++; if (k != 300) begin n_fail++; $display("FAIL to_count: got %0d want 300", k); end
  endtask

  task automatic test_async_reset;
    bit ok;
    fib.FORCE_RESYNC = 1'b0;
    fib.ENA = 1'b1;
    wait_state(3'd5, 400, ok);
    n_chk++; if (!ok || fib.LOSS_CNT !== 8'd1) begin n_fail++; $display("FAIL ar_reach_sync: got ok=%0d loss=%0d want ok=1 loss=1", ok, fib.LOSS_CNT); end
    #2 rst = 1'b1;
    #1;
    n_chk++; if (fib.STATE !== 3'd0) begin n_fail++; $display("FAIL ar_state: got %0d want 0", fib.STATE); end
    n_chk++; if ({fib.TRG_TX_PLLRST, fib.TRG_GTXTXRST, fib.TRG_RST, fib.LINK_UP} !== 4'b1110) begin n_fail++; $display("FAIL ar_outputs: got %b want 1110", {fib.TRG_TX_PLLRST, fib.TRG_GTXTXRST, fib.TRG_RST, fib.LINK_UP}); end
    n_chk++; if ({fib.RETRY_CNT, fib.LOSS_CNT, fib_s.RETRY_CNT} !== 24'h000000) begin n_fail++; $display("FAIL ar_cnts: got %h want 000000", {fib.RETRY_CNT, fib.LOSS_CNT, fib_s.RETRY_CNT}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lock_loss();
    test_force_resync();
    test_rdone_loss_comma();
    test_coincident();
    test_pll_timeout();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tmb_fiber_tx_seq.md
# tmb_fiber_tx_seq

Power-up and recovery sequencer for the TMB trigger fiber transmitter. It drives the GTX TX PLL reset, the GTX TX reset and the link-level reset in order, and waits on PLL lock, TX reset-done and TX phase-alignment done. It then holds the link in comma-only mode for a fixed interval before releasing payload data. It sits beside `tmb_fiber_out`, monitors lock and reset-done continuously, and restarts the sequence on loss or timeout.

## Interface
Parameters:
- PLLRST_CYC, 16 — cycles TRG_TX_PLLRST is held high per attempt (2..65535).
- GTXRST_CYC, 16 — cycles TRG_GTXTXRST is held high per attempt (2..65535).
- WAIT_TMO, 50000 — timeout in cycles for each wait state (lock, reset-done, sync-done).
- COMMA_CYC, 256 — cycles of comma-only transmission before RUN.
- SIM_SPEEDUP, 0 — when 1, WAIT_TMO and COMMA_CYC are both replaced by 64.

Ports:
- TRG_CLK80  in  1  free-running 80 MHz clock; every flop in the block uses it.
- RST  in  1  asynchronous, active-high reset.
- ENA  in  1  link enable. Low forces the OFF state.
- FORCE_RESYNC  in  1  rising edge restarts the sequence from PLL_RST.
- TRG_TX_PLL_LOCK  in  1  GTX TX PLL lock. Asynchronous; synchronized internally.
- TRG_TXRESETDONE  in  1  GTX TX reset done. Asynchronous; synchronized internally.
- TX_SYNC_DONE  in  1  TX phase alignment complete. Asynchronous; synchronized internally.
- TRG_TX_PLLRST  out  1  to the GTX PLL reset.
- TRG_GTXTXRST  out  1  to the GTX TX reset.
- TRG_RST  out  1  link reset. High means the transmitter sends commas and the PRBS is held in reset.
- LINK_UP  out  1  high only in RUN.
- STATE  out  3  current state encoding.
- RETRY_CNT  out  8  count of timeout restarts, saturating.
- LOSS_CNT  out  8  count of lock/reset-done losses while in RUN, saturating.

## Operation
- Synchronizers: each asynchronous input passes through 2 flops. FORCE_RESYNC is edge-detected after its synchronizer.
- State encoding: OFF=0, PLL_RST=1, PLL_WAIT=2, GTX_RST=3, DONE_WAIT=4, SYNC_WAIT=5, COMMA=6, RUN=7.
- Timer: 16-bit down-counter. It is loaded on every state entry with (N−1), where N is the state's length or timeout. It holds at 0.
- OFF: all three resets high. Leave for PLL_RST when ENA=1.
- PLL_RST: TRG_TX_PLLRST, TRG_GTXTXRST and TRG_RST all high. After exactly PLLRST_CYC cycles, go to PLL_WAIT.
- PLL_WAIT: TRG_TX_PLLRST low; the other two resets stay high.
  - Synced lock=1 → GTX_RST.
  - Timer reaches 0 without lock → PLL_RST and RETRY_CNT+1.
- GTX_RST: TRG_GTXTXRST high for exactly GTXRST_CYC cycles, then DONE_WAIT.
- DONE_WAIT: TRG_GTXTXRST low.
  - Synced resetdone=1 → SYNC_WAIT.
  - Timeout → PLL_RST and RETRY_CNT+1.
- SYNC_WAIT:
  - Synced sync_done=1 → COMMA.
  - Timeout → GTX_RST and RETRY_CNT+1.
- COMMA: TRG_RST stays high for COMMA_CYC cycles, then RUN.
- RUN: TRG_RST low and LINK_UP high.
- Loss handling, checked in every state after PLL_WAIT:
  - Synced lock=0 → PLL_RST.
  - Synced resetdone=0 in SYNC_WAIT, COMMA or RUN → GTX_RST.
  - LOSS_CNT increments only when the loss occurs in RUN.
- Priority when events coincide, highest first: ENA=0 (→OFF), FORCE_RESYNC edge (→PLL_RST), lock loss, resetdone loss, timeout/normal advance.
- Counters: RETRY_CNT and LOSS_CNT saturate at 255 and clear only on RST.
- Output encoding: all outputs are registered, decoded from the next-state value so they change in the same cycle as STATE.

## Timing
- Reset values:
  - STATE=OFF (0).
  - TRG_TX_PLLRST=1, TRG_GTXTXRST=1, TRG_RST=1.
  - LINK_UP=0, RETRY_CNT=0, LOSS_CNT=0.
  - Timer=0; synchronizer flops=0.
- RST assertion mid-sequence: all of the above takes effect immediately (asynchronous).
- Input latency: an input change is visible in STATE on the 3rd rising edge after it settles (2 synchronizer flops + 1 state register).
- Minimum time from ENA=1 to LINK_UP=1, with instant responses from the GTX, is PLLRST_CYC + GTXRST_CYC + COMMA_CYC + 10 cycles (±1).
- TRG_TX_PLLRST pulse width is exactly PLLRST_CYC cycles. TRG_GTXTXRST in GTX_RST is exactly GTXRST_CYC cycles.
- A lock or resetdone input that is already high on entry to the corresponding wait state causes the advance after 1 cycle in that state.

## Test plan
- Nominal bring-up: RST released, ENA=1, and the GTX model raises lock, resetdone and sync_done 5 cycles after each request.
  - Pulse widths are 16 and 16 cycles.
  - TRG_RST falls exactly 256 cycles after COMMA is entered.
  - LINK_UP=1; RETRY_CNT=0.
- PLL lock timeout: lock is never asserted with SIM_SPEEDUP=1.
  - Expect PLL_RST re-entered every 16+64 cycles.
  - RETRY_CNT counts 1, 2, 3…; drive 300 timeouts and check it saturates at 255.
- Lock loss in RUN: drop lock for 10 cycles.
  - Within 3 cycles: LINK_UP=0, TRG_RST=1, STATE=1.
  - LOSS_CNT=1; full sequence replays.
- Resetdone loss in COMMA: deassert resetdone.
  - STATE=3 and TRG_GTXTXRST=1.
  - LOSS_CNT unchanged.
- Coincident events: FORCE_RESYNC edge in the same cycle as lock loss, and separately ENA=0 together with FORCE_RESYNC.
  - First case → PLL_RST.
  - Second case → OFF with all resets high.
- Async RST asserted in SYNC_WAIT: all outputs take their reset values before the next clock edge. Counters are cleared.
